// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, PC defaults,
// the reset instruction and the branch-offset helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  // Word-aligned branch displacement: sign-extended immediate shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC: sequential increment, optionally plus the branch displacement.
module pc_next
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_INC = PC_INC_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic        npc_sel,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] branch_pc;

  assign seq_pc    = pc + PC_INC;
  assign branch_pc = seq_pc + branch_offset(imm);
  assign next_pc   = npc_sel ? branch_pc : seq_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, settle, optional data access, commit.
// Define INSTR_COUNT_EN to build the retired-instruction counter.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        is_lw,
  input  logic        is_sw,
  input  logic        npc_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        commit,
  output logic [31:0] pc,
  output logic        busy,
  output logic [31:0] retired_cnt
);

  state_t      state;
  logic [31:0] next_pc;

  pc_next #(
    .PC_INC(PC_INC)
  ) u_pc_next (
    .pc     (pc),
    .imm    (inst[15:0]),
    .npc_sel(npc_sel),
    .next_pc(next_pc)
  );

  assign imem_addr = pc;

  // Outputs are registered alongside the state so each one is valid for the
  // whole cycle the FSM spends in the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst     <= NOP_INST;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      commit   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            inst     <= imem_rdata;
            imem_req <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // An illegal lw+sw decode follows the store path since dmem_we tracks is_sw.
          if (is_lw || is_sw) begin
            state    <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= is_sw;
          end else begin
            state  <= COMMIT;
            commit <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state    <= COMMIT;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            commit   <= 1'b1;
          end
        end
        COMMIT: begin
          commit <= 1'b0;
          pc     <= next_pc;
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          commit   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else if (commit) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: flag-based behavioural model checked every
// cycle, plus directed instructions with hand-computed PCs, latencies and handshakes.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic        npc_take = 1'b0;
  logic        force_both = 1'b0;

  logic        imem_req, dmem_req, dmem_we, commit, busy;
  logic [31:0] imem_addr, inst, pc, retired_cnt;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_commit, w_busy;
  logic [31:0] w_imem_addr, w_inst, w_pc, w_retired_cnt;

  logic is_lw, is_sw, npc_sel;

  // Minimal MIPS-style decoder standing in for the real control unit.
  assign is_lw   = force_both | (inst[31:26] == 6'h23);
  assign is_sw   = force_both | (inst[31:26] == 6'h2b);
  assign npc_sel = npc_take;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .is_lw(is_lw), .is_sw(is_sw), .npc_sel(npc_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .commit(commit), .pc(pc), .busy(busy), .retired_cnt(retired_cnt)
  );

  // Same stimulus with the PC starting one word below zero, so its PC trails by 4.
  instr_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(w_inst), .is_lw(is_lw), .is_sw(is_sw), .npc_sel(npc_sel),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
    .commit(w_commit), .pc(w_pc), .busy(w_busy), .retired_cnt(w_retired_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef INSTR_COUNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  // Behavioural model: one flag per activity of the instruction in flight.
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0, m_cnt = 32'h0;
  bit m_fetching = 0, m_settling = 0, m_mem = 0, m_mem_we = 0, m_committing = 0;
  int m_off;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_inst = 32'h0; m_cnt = 32'h0;
      m_fetching = 0; m_settling = 0; m_mem = 0; m_mem_we = 0; m_committing = 0;
    end else if (m_committing) begin
      m_off = $signed(m_inst[15:0]);
      m_pc = m_pc + 32'd4 + (npc_sel ? 32'(m_off * 4) : 32'd0);
`ifdef INSTR_COUNT_EN
      m_cnt = m_cnt + 32'd1;
`endif
      m_committing = 0;
      m_fetching = run;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_inst = imem_rdata;
        m_fetching = 0;
        m_settling = 1;
      end
    end else if (m_settling) begin
      m_settling = 0;
      if (is_lw || is_sw) begin
        m_mem = 1;
        m_mem_we = is_sw;
      end else begin
        m_committing = 1;
      end
    end else if (m_mem) begin
      if (dmem_ack) begin
        m_mem = 0;
        m_committing = 1;
      end
    end else begin
      m_fetching = run;
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check_output("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
    check_output("imem_addr", imem_addr, m_pc);
    check_output("pc", pc, m_pc);
    check_output("inst", inst, m_inst);
    check_output("dmem_req", {31'd0, dmem_req}, {31'd0, m_mem});
    if (m_mem) check_output("dmem_we", {31'd0, dmem_we}, {31'd0, m_mem_we});
    check_output("commit", {31'd0, commit}, {31'd0, m_committing});
    check_output("busy", {31'd0, busy},
                 {31'd0, m_fetching | m_settling | m_mem | m_committing});
    check_output("retired_cnt", retired_cnt, m_cnt);
    check_output("wrap_pc", w_pc, m_pc - 32'd4);
    check_output("wrap_commit", {31'd0, w_commit}, {31'd0, m_committing});
  end

  int  mon_dreq = 0, mon_commit = 0;
  bit  mon_we = 0;

  always @(negedge clk) begin
    if (dmem_req) mon_dreq++;
    if (commit) mon_commit++;
    if (dmem_req && dmem_we) mon_we = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction through fetch, optional data access and commit.
  task automatic apply_stimulus(input logic [31:0] word, input int fwait, input int mwait,
                                input logic take, input logic stray, input logic drop_run,
                                output int lat, output int dreq, output bit we, output int commits);
    int  g;
    int  t0;
    bit  is_mem;
    lat = 0; dreq = 0; we = 0; commits = 0;
    imem_rdata = word;
    npc_take   = take;
    is_mem     = force_both || (word[31:26] == 6'h23) || (word[31:26] == 6'h2b);
    mon_dreq = 0; mon_commit = 0; mon_we = 0;
    g = 0;
    while (!imem_req && g < 20) begin step(); g++; end
    if (!imem_req) begin check_output("fetch_timeout", 32'd0, 32'd1); return; end
    t0 = cyc;
    repeat (fwait) step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    if (stray) begin
      imem_ack = 1'b1; dmem_ack = 1'b1;
      step();
      imem_ack = 1'b0; dmem_ack = 1'b0;
    end
    if (is_mem) begin
      g = 0;
      while (!dmem_req && g < 20) begin step(); g++; end
      if (!dmem_req) begin check_output("dmem_timeout", 32'd0, 32'd1); return; end
      if (drop_run) run = 1'b0;
      repeat (mwait) step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
    g = 0;
    while (!commit && g < 20) begin step(); g++; end
    if (!commit) begin check_output("commit_timeout", 32'd0, 32'd1); return; end
    lat = cyc - t0 + 1;
    step();
    dreq = mon_dreq; we = mon_we; commits = mon_commit;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int lat, dreq, commits;
  bit we;

  initial begin
    repeat (2) step();
    check_output("reset_pc", pc, 32'h0);
    check_output("reset_inst", inst, 32'h0);
    check_output("reset_imem_req", {31'd0, imem_req}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_cnt", retired_cnt, 32'd0);
    check_output("reset_wrap_pc", w_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Stray acks while idle.
    imem_ack = 1'b1; dmem_ack = 1'b1;
    step(); step();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check_output("idle_stray_busy", {31'd0, busy}, 32'd0);
    check_output("idle_stray_req", {31'd0, imem_req}, 32'd0);
    check_output("idle_stray_pc", pc, 32'h0);

    run = 1'b1;
    apply_stimulus(32'h0022_0820, 0, 0, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("add_latency", 32'(lat), 32'd3);
    check_output("add_pc", pc, 32'h4);
    check_output("add_cnt", retired_cnt, exp_cnt(1));
    check_output("wrap_pc_zero", w_pc, 32'h0);

    apply_stimulus(32'h0022_0820, 2, 0, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("add_wait_latency", 32'(lat), 32'd5);
    check_output("add_wait_pc", pc, 32'h8);

    apply_stimulus(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("beq_taken_pc", pc, 32'h8);

    apply_stimulus(32'h1000_FFFF, 0, 0, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("beq_not_taken_pc", pc, 32'hC);

    apply_stimulus(32'h8C41_0000, 0, 3, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("lw_dreq_cycles", 32'(dreq), 32'd4);
    check_output("lw_we", {31'd0, we}, 32'd0);
    check_output("lw_commits", 32'(commits), 32'd1);
    check_output("lw_latency", 32'(lat), 32'd7);
    check_output("lw_pc", pc, 32'h10);

    apply_stimulus(32'hAC41_0000, 1, 1, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("sw_we", {31'd0, we}, 32'd1);
    check_output("sw_latency", 32'(lat), 32'd6);
    check_output("sw_pc", pc, 32'h14);

    force_both = 1'b1;
    apply_stimulus(32'h0022_0820, 0, 0, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    force_both = 1'b0;
    check_output("both_we", {31'd0, we}, 32'd1);
    check_output("both_pc", pc, 32'h18);

    apply_stimulus(32'h8C41_0000, 0, 1, 1'b0, 1'b1, 1'b0, lat, dreq, we, commits);
    check_output("stray_lw_latency", 32'(lat), 32'd5);
    check_output("stray_lw_dreq", 32'(dreq), 32'd2);
    check_output("stray_lw_pc", pc, 32'h1C);

    apply_stimulus(32'h0022_0820, 0, 0, 1'b0, 1'b1, 1'b0, lat, dreq, we, commits);
    check_output("stray_add_latency", 32'(lat), 32'd3);
    check_output("stray_add_pc", pc, 32'h20);

    apply_stimulus(32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("beq_fwd_pc", pc, 32'h30);

    apply_stimulus(32'h8C41_0000, 0, 2, 1'b0, 1'b0, 1'b1, lat, dreq, we, commits);
    check_output("drop_commits", 32'(commits), 32'd1);
    check_output("drop_pc", pc, 32'h34);
    check_output("drop_busy", {31'd0, busy}, 32'd0);
    check_output("drop_cnt", retired_cnt, exp_cnt(11));
    step(); step();
    check_output("drop_idle_req", {31'd0, imem_req}, 32'd0);
    check_output("drop_idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a fetch.
    run = 1'b1;
    step(); step();
    check_output("refetch_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_fetch_req", {31'd0, imem_req}, 32'd0);
    check_output("rst_fetch_pc", pc, 32'h0);
    check_output("rst_fetch_busy", {31'd0, busy}, 32'd0);
    check_output("rst_fetch_cnt", retired_cnt, 32'd0);
    step();
    rst_n = 1'b1;

    apply_stimulus(32'h0022_0820, 0, 0, 1'b0, 1'b0, 1'b0, lat, dreq, we, commits);
    check_output("post_rst_latency", 32'(lat), 32'd3);
    check_output("post_rst_pc", pc, 32'h4);
    check_output("post_rst_cnt", retired_cnt, exp_cnt(1));

    run = 1'b0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
